// File: rtl/multicore_launcher.sv
// multicore_launcher: run controller for the 4-core processor.
// Sequences one launch as IDLE -> CLEAR -> RUN -> DONE. It drives the per-core
// status enables and gathers completion from end_process. A run ends when every
// selected core has finished or when the watchdog expires.
// Every output is decoded from registered state, so no input reaches an output
// through combinational logic only.

module multicore_launcher #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 60000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       core_mask,
  input  logic [3:0]       end_process,
  output logic [1:0]       status0,
  output logic [1:0]       status1,
  output logic [1:0]       status2,
  output logic [1:0]       status3,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [3:0]       fin_mask,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Per-core enable codes. 2'b11 is never driven.
  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_CLEAR = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b01;

  // The watchdog fires on the edge that closes RUN cycle MAX_CYCLES.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       fin_q, fin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  // end_process is wired core0-first from the MSB. Reorder it so that
  // bit i is core i, matching core_mask and fin_mask.
  logic [3:0] end_core;
  assign end_core = {end_process[0], end_process[1], end_process[2], end_process[3]};

  // Completion view that includes ends arriving on the current edge.
  logic [3:0] fin_next;
  logic       all_fin;

  // Next-state and datapath update for the launch sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case. A path that leaves
    // one unassigned would infer a latch.
    state_d  = state_q;
    mask_d   = mask_q;
    fin_d    = fin_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    fin_next = fin_q | (end_core & mask_q);
    all_fin  = ((fin_next & mask_q) == mask_q);

    case (state_q)
      S_IDLE: begin
        // start is sampled here only. A request in any other state is dropped.
        if (start) begin
          state_d = S_CLEAR;
          mask_d  = core_mask;
          fin_d   = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end

      S_CLEAR: begin
        // One clear cycle. Core ends seen during it are ignored.
        state_d = S_RUN;
      end

      S_RUN: begin
        fin_d = fin_next;
        cnt_d = cnt_q + CNT_W'(1);
        // Completion is tested first, so it wins over a simultaneous expiry.
        if (all_fin) begin
          state_d = S_DONE;
          to_d    = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
      end

      S_DONE: begin
        // fin_mask, timeout and cycle_count are held for the host to read.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers, with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      fin_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from the values they held before the edge.
      state_q <= state_d;
      mask_q  <= mask_d;
      fin_q   <= fin_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Per-core enable decode, taken from registered state only.
  logic [1:0] status_w [4];

  // A core enters RUN after CLEAR. It drops to OFF the cycle after its end flag
  // is captured into fin_q.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      status_w[i] = ST_OFF;
      if (mask_q[i]) begin
        if (state_q == S_CLEAR) begin
          status_w[i] = ST_CLEAR;
        end else if (state_q == S_RUN && !fin_q[i]) begin
          status_w[i] = ST_RUN;
        end
      end
    end
  end

  assign status0     = status_w[0];
  assign status1     = status_w[1];
  assign status2     = status_w[2];
  assign status3     = status_w[3];
  assign busy        = (state_q == S_CLEAR) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign timeout     = to_q;
  assign fin_mask    = fin_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_multicore_launcher.sv
// Testbench for multicore_launcher. The watchdog is set to 20 cycles so that
// timeout cases run quickly.
// A run is described by the mask and the RUN cycle on which each core raises
// its end flag (0 means the core never ends). Expected status, fin_mask,
// cycle_count and timeout are derived from that description.

module tb_multicore_launcher;

  localparam int CNT_W = 16;
  localparam int MAXC  = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       core_mask;
  logic [3:0]       end_process;
  logic [1:0]       status0, status1, status2, status3;
  logic             busy, done, timeout;
  logic [3:0]       fin_mask;
  logic [CNT_W-1:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  multicore_launcher #(.CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_mask   (core_mask),
    .end_process (end_process),
    .status0     (status0),
    .status1     (status1),
    .status2     (status2),
    .status3     (status3),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .fin_mask    (fin_mask),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  logic [7:0] st_all;
  assign st_all = {status3, status2, status1, status0};

  typedef struct {
    logic [3:0]      mask;
    logic [3:0][7:0] ends;   // ends[i] = RUN cycle of core i's end flag, 0 = never
    bit              level;  // 1: flag stays high from its cycle on, 0: one-cycle pulse
    int              exp_k;
    bit              exp_to;
    logic [3:0]      exp_fin;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected packed status word {status3..status0}. k == 0 selects the CLEAR cycle.
  function automatic logic [7:0] exp_status(input logic [3:0] mask,
                                            input logic [3:0][7:0] e, input int k);
    logic [7:0] s = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        if (k == 0) s[2*i +: 2] = 2'b10;
        else if (e[i] == 0 || int'(e[i]) >= k) s[2*i +: 2] = 2'b01;
      end
    end
    return s;
  endfunction

  // Run outcome from the mask and the per-core end cycles.
  function automatic void model(input logic [3:0] mask, input logic [3:0][7:0] e,
                                output int k, output bit to, output logic [3:0] fin);
    int  need  = 0;
    bit  never = 1'b0;
    fin = '0;
    if (mask == 4'b0000) begin
      k = 1; to = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        if (e[i] == 0 || int'(e[i]) > MAXC) never = 1'b1;
        else if (int'(e[i]) > need) need = int'(e[i]);
        if (e[i] != 0 && int'(e[i]) <= MAXC) fin[i] = 1'b1;
      end
    end
    if (!never) begin
      k = need; to = 1'b0; fin = mask;
    end else begin
      k = MAXC; to = 1'b1;
    end
  endfunction

  // One full launch, checked cycle by cycle from IDLE through DONE and one hold cycle.
  task automatic run_launch(input int id, input logic [3:0] mask, input logic [3:0][7:0] e,
                            input bit level, input int exp_k, input bit exp_to,
                            input logic [3:0] exp_fin);
    logic [3:0] ep;
    logic [3:0] fin_now;
    @(negedge clk);
    start = 1'b1; core_mask = mask; end_process = 4'b0000;
    @(negedge clk);
    // CLEAR cycle. Scramble the inputs: the mask is already latched and ends are ignored.
    start = 1'b0; core_mask = ~mask; end_process = 4'hF;
    check($sformatf("r%0d clear status", id), 32'(st_all), 32'(exp_status(mask, e, 0)));
    check($sformatf("r%0d clear busy", id), 32'(busy), 32'(1));
    check($sformatf("r%0d clear count", id), 32'(cycle_count), 32'(0));
    check($sformatf("r%0d clear fin", id), 32'(fin_mask), 32'(0));
    check($sformatf("r%0d clear timeout", id), 32'(timeout), 32'(0));
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clk);
      fin_now = '0;
      for (int i = 0; i < 4; i++)
        if (mask[i] && e[i] != 0 && int'(e[i]) < k) fin_now[i] = 1'b1;
      check($sformatf("r%0d k%0d status", id, k), 32'(st_all), 32'(exp_status(mask, e, k)));
      check($sformatf("r%0d k%0d busy", id, k), 32'(busy), 32'(1));
      check($sformatf("r%0d k%0d done", id, k), 32'(done), 32'(0));
      check($sformatf("r%0d k%0d count", id, k), 32'(cycle_count), 32'(k - 1));
      check($sformatf("r%0d k%0d fin", id, k), 32'(fin_mask), 32'(fin_now));
      ep = '0;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (e[i] != 0 && (level ? (k >= int'(e[i])) : (k == int'(e[i])))) ep[3-i] = 1'b1;
        end else begin
          ep[3-i] = 1'($urandom_range(0, 1));
        end
      end
      end_process = ep;
    end
    @(negedge clk);
    end_process = 4'b0000;
    check($sformatf("r%0d done pulse", id), 32'(done), 32'(1));
    check($sformatf("r%0d done busy", id), 32'(busy), 32'(0));
    check($sformatf("r%0d done status", id), 32'(st_all), 32'(0));
    check($sformatf("r%0d done count", id), 32'(cycle_count), 32'(exp_k));
    check($sformatf("r%0d done timeout", id), 32'(timeout), 32'(exp_to));
    check($sformatf("r%0d done fin", id), 32'(fin_mask), 32'(exp_fin));
    @(negedge clk);
    check($sformatf("r%0d idle done", id), 32'(done), 32'(0));
    check($sformatf("r%0d idle busy", id), 32'(busy), 32'(0));
    check($sformatf("r%0d hold count", id), 32'(cycle_count), 32'(exp_k));
    check($sformatf("r%0d hold timeout", id), 32'(timeout), 32'(exp_to));
    check($sformatf("r%0d hold fin", id), 32'(fin_mask), 32'(exp_fin));
  endtask

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]      r_mask;
    logic [3:0][7:0] r_e;
    bit              r_level;
    int              m_k;
    bit              m_to;
    logic [3:0]      m_fin;

    //        mask   ends {c3,c2,c1,c0}                 lvl  k   to    fin
    vecs[0] = '{4'hF, {8'd12, 8'd9,  8'd9,  8'd5},  1'b0, 12, 1'b0, 4'hF};
    vecs[1] = '{4'h5, {8'd0,  8'd3,  8'd0,  8'd3},  1'b0, 3,  1'b0, 4'h5};
    vecs[2] = '{4'h1, {8'd0,  8'd0,  8'd0,  8'd0},  1'b0, 20, 1'b1, 4'h0};
    vecs[3] = '{4'h1, {8'd0,  8'd0,  8'd0,  8'd20}, 1'b0, 20, 1'b0, 4'h1};
    vecs[4] = '{4'h0, {8'd0,  8'd0,  8'd0,  8'd0},  1'b0, 1,  1'b0, 4'h0};
    vecs[5] = '{4'hA, {8'd0,  8'd0,  8'd3,  8'd0},  1'b0, 20, 1'b1, 4'h2};
    vecs[6] = '{4'h8, {8'd21, 8'd0,  8'd0,  8'd0},  1'b1, 20, 1'b1, 4'h0};
    vecs[7] = '{4'h6, {8'd0,  8'd1,  8'd1,  8'd0},  1'b1, 1,  1'b0, 4'h6};
    vecs[8] = '{4'hF, {8'd20, 8'd20, 8'd19, 8'd1},  1'b1, 20, 1'b0, 4'hF};

    rst = 1'b1; start = 1'b0; core_mask = 4'b0000; end_process = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset status", 32'(st_all), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset timeout", 32'(timeout), 32'(0));
    check("reset fin", 32'(fin_mask), 32'(0));
    check("reset count", 32'(cycle_count), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle busy", 32'(busy), 32'(0));

    for (int v = 0; v < 9; v++)
      run_launch(v, vecs[v].mask, vecs[v].ends, vecs[v].level,
                 vecs[v].exp_k, vecs[v].exp_to, vecs[v].exp_fin);

    // start held high through CLEAR and RUN: no restart and no queued launch.
    @(negedge clk);
    start = 1'b1; core_mask = 4'b0001; end_process = 4'b0000;
    @(negedge clk);
    check("hold clear busy", 32'(busy), 32'(1));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("hold k%0d count", k), 32'(cycle_count), 32'(k - 1));
      check($sformatf("hold k%0d status", k), 32'(st_all), 32'(8'h01));
      end_process = (k == 3) ? 4'b1000 : 4'b0000;
      if (k == 3) start = 1'b0;
    end
    @(negedge clk);
    end_process = 4'b0000;
    check("hold done", 32'(done), 32'(1));
    check("hold done count", 32'(cycle_count), 32'(3));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("no queue busy %0d", j), 32'(busy), 32'(0));
      check($sformatf("no queue done %0d", j), 32'(done), 32'(0));
    end

    // Reset in the middle of RUN: cores drop to OFF at once and no done pulse follows.
    @(negedge clk);
    start = 1'b1; core_mask = 4'hF;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("midrun busy", 32'(busy), 32'(1));
    check("midrun status", 32'(st_all), 32'(8'h55));
    #2 rst = 1'b1;
    #1;
    check("rst status", 32'(st_all), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst count", 32'(cycle_count), 32'(0));
    check("rst fin", 32'(fin_mask), 32'(0));
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check($sformatf("rst hold done %0d", j), 32'(done), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst release idle", 32'(busy), 32'(0));
    run_launch(50, 4'h3, {8'd0, 8'd0, 8'd4, 8'd2}, 1'b0, 4, 1'b0, 4'h3);

    // Randomized launches against the outcome model.
    for (int n = 0; n < 40; n++) begin
      r_mask  = 4'($urandom_range(0, 15));
      r_level = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++)
        r_e[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 24))
                                             : 8'($urandom_range(1, 18));
      model(r_mask, r_e, m_k, m_to, m_fin);
      run_launch(100 + n, r_mask, r_e, r_level, m_k, m_to, m_fin);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
